// File: rtl/n_way_cache_controller_if.sv
// ============================================================================
// Module   : n_way_cache_controller_if
// Brief    : CPU-side access bus and word-serial RAM bus of the data cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface n_way_cache_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic                  addr_mode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd;
  logic                  ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  // slave = the cache; master = the CPU/RAM environment around it
  modport slave (
    input  req, we, addr_mode, addr, wd, mem_rdata, mem_ack,
    output rd, ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr_mode, addr, wd, mem_rdata, mem_ack,
    input  rd, ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/n_way_cache_controller.sv
// ============================================================================
// Module   : n_way_cache_controller
// Brief    : N-way set-associative write-back/write-allocate data cache with
//            tree-PLRU replacement; CACHE_STATS_EN adds hit/miss/wb counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module n_way_cache_controller #(
  parameter int WAYS           = 4,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  n_way_cache_controller_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o,
  output logic [31:0]             wb_count_o
`endif
);

  localparam int IDX_BITS  = $clog2(SETS);
  localparam int IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int WIDX_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int OFF_W     = WORD_BITS + 2;
  localparam int TAG_W     = ADDR_WIDTH - IDX_BITS - OFF_W;
  localparam int WAY_W     = $clog2(WAYS);
  localparam int PLRU_W    = WAYS - 1;
  localparam int PIDX_W    = (WAYS > 2) ? $clog2(PLRU_W) : 1;
  localparam logic [WIDX_W-1:0] LAST_BEAT = WIDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  // PLRU tree is heap-ordered: node n has children 2n and 2n+1, bit=1 means the victim is right
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int node;
    node = 1;
    for (int l = 0; l < WAY_W; l++)
      node = 2 * node + (bits[PIDX_W'(node - 1)] ? 1 : 0);
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] nb;
    int node;
    int dir;
    nb   = bits;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      dir                   = (int'(way) >> (WAY_W - 1 - l)) & 1;
      nb[PIDX_W'(node - 1)] = (dir == 0);
      node                  = 2 * node + dir;
    end
    return nb;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [TAG_W-1:0]  t,
                                                      input logic [IDX_W-1:0]  s,
                                                      input logic [WIDX_W-1:0] b);
    logic [ADDR_WIDTH-1:0] a;
    a = (ADDR_WIDTH'(t) << (IDX_BITS + OFF_W)) | (ADDR_WIDTH'(s) << OFF_W);
    if (WORDS_PER_LINE > 1) a = a | (ADDR_WIDTH'(b) << 2);
    return a;
  endfunction

  logic [TAG_W-1:0]      tags_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][WORDS_PER_LINE];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [PLRU_W-1:0]     plru_q  [SETS];

  state_t                state_q;
  logic [WIDX_W-1:0]     beat_q;
  logic [WAY_W-1:0]      victim_q;
  logic [IDX_W-1:0]      set_q;
  logic [TAG_W-1:0]      rtag_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_set;
  logic [WIDX_W-1:0]     req_word;
  logic [1:0]            req_byte;
  logic                  lookup;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_found;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      victim;
  logic                  evict_dirty;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [7:0]            ld_byte;
  logic [DATA_WIDTH-1:0] st_word;
  logic                  store_en;
  logic                  refill_en;
  logic                  refill_last;
  logic [WIDX_W-1:0]     beat_d;

  assign req_tag  = TAG_W'(bus.addr >> (IDX_BITS + OFF_W));
  assign req_set  = IDX_W'(bus.addr >> OFF_W) & IDX_W'(SETS - 1);
  assign req_word = WIDX_W'(bus.addr >> 2) & WIDX_W'(WORDS_PER_LINE - 1);
  assign req_byte = bus.addr[1:0];

  // Descending scan so the lowest-index invalid way wins
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][WAY_W'(w)] && (tags_q[req_set][WAY_W'(w)] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_set][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim      = inv_found ? inv_way : plru_victim(plru_q[req_set]);
  assign evict_dirty = valid_q[req_set][victim] && dirty_q[req_set][victim];
  assign lookup      = (state_q == IDLE) && bus.req;
  assign hit_word    = data_q[req_set][hit_way][req_word];
  assign ld_byte     = 8'(hit_word >> {req_byte, 3'b000});

  always_comb begin
    st_word = bus.wd;
    if (bus.addr_mode) begin
      st_word                          = hit_word;
      st_word[{req_byte, 3'b000} +: 8] = bus.wd[7:0];
    end
  end

  assign bus.ready     = lookup && hit;
  assign bus.rd        = (bus.ready && !bus.we)
                         ? (bus.addr_mode ? DATA_WIDTH'(ld_byte) : hit_word) : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign store_en    = bus.ready && bus.we;
  assign refill_en   = (state_q == REFILL) && bus.mem_ack;
  assign refill_last = refill_en && (beat_q == LAST_BEAT);
  assign beat_d      = beat_q + 1'b1;

  // Line payload and tags carry no reset; the valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (store_en)
      data_q[req_set][hit_way][req_word] <= st_word;
    if (refill_en)
      data_q[set_q][victim_q][beat_q] <= bus.mem_rdata;
    if (refill_last)
      tags_q[set_q][victim_q] <= rtag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      victim_q    <= '0;
      set_q       <= '0;
      rtag_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[IDX_W'(s)] <= '0;
        dirty_q[IDX_W'(s)] <= '0;
        plru_q[IDX_W'(s)]  <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            if (hit) begin
              plru_q[req_set] <= plru_touch(plru_q[req_set], hit_way);
              if (bus.we) dirty_q[req_set][hit_way] <= 1'b1;
            end else begin
              victim_q  <= victim;
              set_q     <= req_set;
              rtag_q    <= req_tag;
              beat_q    <= '0;
              mem_req_q <= 1'b1;
              if (evict_dirty) begin
                state_q     <= WRITEBACK;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= beat_addr(tags_q[req_set][victim], req_set, '0);
                mem_wdata_q <= data_q[req_set][victim][0];
              end else begin
                state_q     <= REFILL;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= beat_addr(req_tag, req_set, '0);
                mem_wdata_q <= '0;
              end
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack) begin
            if (beat_q == LAST_BEAT) begin
              state_q     <= REFILL;
              beat_q      <= '0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= beat_addr(rtag_q, set_q, '0);
              mem_wdata_q <= '0;
            end else begin
              beat_q      <= beat_d;
              mem_addr_q  <= beat_addr(tags_q[set_q][victim_q], set_q, beat_d);
              mem_wdata_q <= data_q[set_q][victim_q][beat_d];
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            if (beat_q == LAST_BEAT) begin
              state_q                  <= IDLE;
              beat_q                   <= '0;
              mem_req_q                <= 1'b0;
              mem_addr_q               <= '0;
              valid_q[set_q][victim_q] <= 1'b1;
              dirty_q[set_q][victim_q] <= 1'b0;
            end else begin
              beat_q     <= beat_d;
              mem_addr_q <= beat_addr(rtag_q, set_q, beat_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] wb_cnt_q;

  // The hit that follows a refill is the replay of the same request, not a new hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      replay_q <= refill_last;
      if (bus.ready && !replay_q && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (lookup && !hit && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 32'd1;
      if (lookup && !hit && evict_dirty && (wb_cnt_q != '1))
        wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
  assign wb_count_o   = wb_cnt_q;
`endif

endmodule

`default_nettype wire
